div_seq: RTL and testbench



---
 rtl/div_seq.sv | 139 +++++++++++++
 tb/tb_div_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential radix-2 restoring fixed-point divider: o = (a << O_F_W) / b.
// Ports: clk, rst_n, in_valid/in_ready (a, b), out_valid/out_ready (o, ovf, dz).
module div_seq #(
    parameter int A_W   = 9,
    parameter int B_W   = 9,
    parameter int O_I_W = 4,
    parameter int O_F_W = 8,
    parameter int O_W   = O_I_W + O_F_W,
    parameter int ROUND = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [O_W-1:0] o,
    output logic           ovf,
    output logic           dz
);

    localparam int N  = A_W + O_F_W;
    localparam int CW = $clog2(N + 1);
    // Wide enough for the rounded quotient plus at least one overflow bit.
    localparam int QW = (N + 1 > O_W + 1) ? N + 1 : O_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nx;

    // dvd shifts dividend bits out of the top and quotient bits in at the
    // bottom, so after N steps it holds the full quotient.
    logic [N-1:0]   dvd;
    logic [B_W-1:0] bq;
    logic [B_W:0]   rem;
    logic [CW-1:0]  cnt;

    logic [B_W+1:0] rem_sh;
    logic [B_W+1:0] rem_nx;
    logic           qbit;
    logic [N-1:0]   q_full;
    logic           rnd;
    logic [QW-1:0]  q_ext;
    logic           sat;
    logic           last;

    always_comb begin
        rem_sh = {rem, dvd[N-1]};
        qbit   = rem_sh >= {2'b00, bq};
        rem_nx = qbit ? rem_sh - {2'b00, bq} : rem_sh;
        q_full = {dvd[N-2:0], qbit};
        rnd    = 1'b0;
        if (ROUND != 0) begin
            rnd = {rem_nx, 1'b0} >= {3'b000, bq};
        end
        q_ext = QW'(q_full) + QW'(rnd);
        sat   = |q_ext[QW-1:O_W];
        last  = (cnt == CW'(1));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = (b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd <= '0;
            bq  <= '0;
            rem <= '0;
            cnt <= '0;
            o   <= '0;
            ovf <= 1'b0;
            dz  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd <= {a, {O_F_W{1'b0}}};
                        bq  <= b;
                        rem <= '0;
                        cnt <= CW'(N);
                        if (b == '0) begin
                            o   <= '1;
                            ovf <= 1'b0;
                            dz  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd <= q_full;
                    rem <= rem_nx[B_W:0];
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        o   <= sat ? '1 : q_ext[O_W-1:0];
                        ovf <= sat;
                        dz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: truncating and rounding instances
// share stimulus; vector table plus backpressure and reset sequences.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [8:0]  a = '0;
    logic [8:0]  b = '0;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic        ovf0, ovf1, dz0, dz1;
    logic [11:0] o0, o1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq #(.ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b),
        .out_valid(out_valid0), .out_ready(out_ready),
        .o(o0), .ovf(ovf0), .dz(dz0)
    );

    div_seq #(.ROUND(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b),
        .out_valid(out_valid1), .out_ready(out_ready),
        .o(o1), .ovf(ovf1), .dz(dz1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Offers one operand pair, returns edges from accept to out_valid.
    task automatic op(input logic [8:0] va, input logic [8:0] vb,
                      output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        lat = 0;
        while (!out_valid0 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [8:0]  a;
        logic [8:0]  b;
        logic [11:0] o0;
        logic [11:0] o1;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vt[13];

    initial begin
        int lat;

        vt[0]  = '{9'd3,   9'd2,   12'h180, 12'h180, 1'b0, 1'b0, 17};
        vt[1]  = '{9'd2,   9'd3,   12'h0AA, 12'h0AB, 1'b0, 1'b0, 17};
        vt[2]  = '{9'd255, 9'd1,   12'hFFF, 12'hFFF, 1'b1, 1'b0, 17};
        vt[3]  = '{9'd5,   9'd0,   12'hFFF, 12'hFFF, 1'b0, 1'b1, 0};
        vt[4]  = '{9'd1,   9'd3,   12'h055, 12'h055, 1'b0, 1'b0, 17};
        vt[5]  = '{9'd511, 9'd511, 12'h100, 12'h100, 1'b0, 1'b0, 17};
        vt[6]  = '{9'd15,  9'd1,   12'hF00, 12'hF00, 1'b0, 1'b0, 17};
        vt[7]  = '{9'd16,  9'd1,   12'hFFF, 12'hFFF, 1'b1, 1'b0, 17};
        vt[8]  = '{9'd0,   9'd5,   12'h000, 12'h000, 1'b0, 1'b0, 17};
        vt[9]  = '{9'd5,   9'd3,   12'h1AA, 12'h1AB, 1'b0, 1'b0, 17};
        vt[10] = '{9'd7,   9'd5,   12'h166, 12'h166, 1'b0, 1'b0, 17};
        vt[11] = '{9'd1,   9'd511, 12'h000, 12'h001, 1'b0, 1'b0, 17};
        vt[12] = '{9'd0,   9'd0,   12'hFFF, 12'hFFF, 1'b0, 1'b1, 0};

        #12;
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_o", 32'(o0), 32'd0);
        chk("rst_flags", 32'({ovf0, dz0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            out_ready = 1'b1;
            op(vt[i].a, vt[i].b, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_o_trunc", i), 32'(o0), 32'(vt[i].o0));
            chk($sformatf("v%0d_o_round", i), 32'(o1), 32'(vt[i].o1));
            chk($sformatf("v%0d_ovf", i), 32'({ovf0, ovf1}),
                32'({vt[i].ovf, vt[i].ovf}));
            chk($sformatf("v%0d_dz", i), 32'({dz0, dz1}),
                32'({vt[i].dz, vt[i].dz}));
            chk($sformatf("v%0d_valid_round", i), 32'(out_valid1), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_in_ready_after", i),
                32'({in_ready0, out_valid0}), 32'b10);
        end

        // Backpressure: result held, new offers ignored.
        out_ready = 1'b0;
        op(9'd3, 9'd2, lat);
        chk("bp_lat", 32'(lat), 32'd17);
        for (int k = 0; k < 5; k++) begin
            a = 9'd9;
            b = 9'd1;
            in_valid = 1'b1;
            chk($sformatf("bp_hold_%0d", k),
                32'({out_valid0, in_ready0, o0}), 32'({2'b10, 12'h180}));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 32'({in_ready0, out_valid0, o0}),
            32'({2'b10, 12'h180}));
        op(9'd4, 9'd2, lat);
        chk("bp_next_lat", 32'(lat), 32'd17);
        chk("bp_next_o", 32'(o0), 32'h200);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-calculation.
        op(9'd3, 9'd2, lat);
        @(posedge clk);
        #1;
        @(negedge clk);
        a = 9'd3;
        b = 9'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_state", 32'({out_valid0, in_ready0}), 32'b01);
        chk("rst_mid_o", 32'(o0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid0) break;
        end
        chk("rst_no_result", 32'(out_valid0), 32'd0);
        op(9'd4, 9'd2, lat);
        chk("rst_after_lat", 32'(lat), 32'd17);
        chk("rst_after_o", 32'({o0, ovf0, dz0}), 32'({12'h200, 2'b00}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
